// File: rtl/tile_viewport_renderer_pkg.sv
// ============================================================================
// render_pkg : shared types and constants for the tile viewport renderer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package render_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    TILE_VOID  = 2'd0,
    TILE_GRASS = 2'd1,
    TILE_WATER = 2'd2,
    TILE_SAND  = 2'd3
  } tile_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef logic [23:0] rgb_t;

  localparam rgb_t c_key_rgb_default = 24'hFF00D2;

  // Address width for a ROM of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_viewport_renderer_addr_gen.sv
// ============================================================================
// viewport_addr_gen : S0 world-coordinate and ROM address math for one view
// Revision          : 1.0
// ============================================================================
`default_nettype none

module viewport_addr_gen
  import render_pkg::*;
#(
  parameter int TILE_LOG2 = 5,
  parameter int MAP_W     = 100,
  parameter int MAP_H     = 75,
  parameter int VIEW_W    = 640,
  parameter int VIEW_H    = 480,
  parameter int SPR_SIZE  = 75,
  parameter int COORD_W   = 12,
  parameter int MAP_AW    = addr_width(MAP_W * MAP_H),
  parameter int SPR_AW    = addr_width(4 * SPR_SIZE * SPR_SIZE)
) (
  input  logic [COORD_W-1:0]   cam_x,
  input  logic [COORD_W-1:0]   cam_y,
  input  logic [1:0]           dir,
  input  logic [9:0]           draw_x,
  input  logic [9:0]           draw_y,
  output logic [TILE_LOG2-1:0] wx_lo,
  output logic [TILE_LOG2-1:0] wy_lo,
  output logic                 in_map,
  output logic                 in_spr,
  output logic                 blank,
  output logic [MAP_AW-1:0]    map_addr,
  output logic [SPR_AW-1:0]    spr_addr
);

  localparam int c_tile_px = 2 ** TILE_LOG2;

  localparam logic signed [COORD_W:0] c_tile    = (COORD_W+1)'(c_tile_px);
  localparam logic signed [COORD_W:0] c_half_w  = (COORD_W+1)'(VIEW_W / 2);
  localparam logic signed [COORD_W:0] c_half_h  = (COORD_W+1)'(VIEW_H / 2);
  localparam logic signed [COORD_W:0] c_x_end   = (COORD_W+1)'((MAP_W - 1) * c_tile_px);
  localparam logic signed [COORD_W:0] c_y_end   = (COORD_W+1)'((MAP_H - 1) * c_tile_px);

  localparam logic [9:0] c_spr_x0 = 10'(VIEW_W / 2 - SPR_SIZE / 2);
  localparam logic [9:0] c_spr_x1 = 10'(VIEW_W / 2 - SPR_SIZE / 2 + SPR_SIZE);
  localparam logic [9:0] c_spr_y0 = 10'(VIEW_H / 2 - SPR_SIZE / 2);
  localparam logic [9:0] c_spr_y1 = 10'(VIEW_H / 2 - SPR_SIZE / 2 + SPR_SIZE);

  localparam logic [MAP_AW-1:0] c_map_w  = MAP_AW'(MAP_W);
  localparam logic [SPR_AW-1:0] c_spr_sz = SPR_AW'(SPR_SIZE);
  localparam logic [SPR_AW-1:0] c_spr_sq = SPR_AW'(SPR_SIZE * SPR_SIZE);

  logic signed [COORD_W:0] w_wx;
  logic signed [COORD_W:0] w_wy;
  logic [MAP_AW-1:0]       w_tx;
  logic [MAP_AW-1:0]       w_ty;
  logic [9:0]              w_sx;
  logic [9:0]              w_sy;

  // One extra bit keeps camera-minus-half-view signed, so off-map left/top goes negative.
  assign w_wx = $signed({1'b0, cam_x}) - c_half_w + $signed({{(COORD_W-9){1'b0}}, draw_x});
  assign w_wy = $signed({1'b0, cam_y}) - c_half_h + $signed({{(COORD_W-9){1'b0}}, draw_y});

  assign in_map = (w_wx >= c_tile) && (w_wx < c_x_end) &&
                  (w_wy >= c_tile) && (w_wy < c_y_end);

  assign w_tx     = MAP_AW'(w_wx[COORD_W-1:TILE_LOG2]);
  assign w_ty     = MAP_AW'(w_wy[COORD_W-1:TILE_LOG2]);
  assign map_addr = in_map ? (w_ty * c_map_w + w_tx) : '0;

  assign wx_lo = w_wx[TILE_LOG2-1:0];
  assign wy_lo = w_wy[TILE_LOG2-1:0];

  assign in_spr = (draw_x >= c_spr_x0) && (draw_x < c_spr_x1) &&
                  (draw_y >= c_spr_y0) && (draw_y < c_spr_y1);

  assign w_sx     = draw_x - c_spr_x0;
  assign w_sy     = draw_y - c_spr_y0;
  assign spr_addr = in_spr ? (SPR_AW'(dir) * c_spr_sq + SPR_AW'(w_sy) * c_spr_sz + SPR_AW'(w_sx))
                           : '0;

  assign blank = (draw_x >= 10'(VIEW_W)) || (draw_y >= 10'(VIEW_H));

endmodule

`default_nettype wire

// File: rtl/tile_viewport_renderer.sv
// ============================================================================
// tile_viewport_renderer : time-multiplexed N-view tile map + sprite renderer
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tile_viewport_renderer
  import render_pkg::*;
#(
  parameter int         N_VIEWS   = 2,
  parameter int         TILE_LOG2 = 5,
  parameter int         MAP_W     = 100,
  parameter int         MAP_H     = 75,
  parameter int         VIEW_W    = 640,
  parameter int         VIEW_H    = 480,
  parameter int         SPR_SIZE  = 75,
  parameter int         COORD_W   = 12,
  parameter logic [23:0] KEY_RGB  = c_key_rgb_default
) (
  input  logic                                         Clk,
  input  logic                                         Reset_n,
  input  logic                                         pix_ce,
  input  logic [9:0]                                   DrawX,
  input  logic [9:0]                                   DrawY,
  input  logic [N_VIEWS*COORD_W-1:0]                   cam_x,
  input  logic [N_VIEWS*COORD_W-1:0]                   cam_y,
  input  logic [N_VIEWS*2-1:0]                         dir,
  output logic [addr_width(MAP_W*MAP_H)-1:0]           map_addr,
  input  logic [1:0]                                   map_data,
  output logic [2+2*TILE_LOG2-1:0]                     tile_addr,
  input  logic [23:0]                                  tile_data,
  output logic [addr_width(4*SPR_SIZE*SPR_SIZE)-1:0]   spr_addr,
  input  logic [23:0]                                  spr_data,
  output logic [N_VIEWS*24-1:0]                        rgb,
  output logic                                         rgb_valid,
  output logic                                         overrun
);

  localparam int c_map_aw = addr_width(MAP_W * MAP_H);
  localparam int c_spr_aw = addr_width(4 * SPR_SIZE * SPR_SIZE);
  localparam int c_slot_w = addr_width(N_VIEWS);

  localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(N_VIEWS - 1);

  state_e                       r_state;
  logic [c_slot_w-1:0]          r_slot;
  logic                         r_drain;
  logic [9:0]                   r_draw_x;
  logic [9:0]                   r_draw_y;
  logic [N_VIEWS*COORD_W-1:0]   r_cam_x;
  logic [N_VIEWS*COORD_W-1:0]   r_cam_y;
  logic [N_VIEWS*2-1:0]         r_dir;
  logic [N_VIEWS*24-1:0]        r_rgb;
  logic                         r_rgb_valid;
  logic                         r_overrun;

  logic                         r_s1_valid;
  logic [c_slot_w-1:0]          r_s1_view;
  logic                         r_s1_in_map;
  logic                         r_s1_in_spr;
  logic                         r_s1_blank;
  logic [TILE_LOG2-1:0]         r_s1_wx_lo;
  logic [TILE_LOG2-1:0]         r_s1_wy_lo;

  logic                         r_s2_valid;
  logic [c_slot_w-1:0]          r_s2_view;
  logic                         r_s2_in_map;
  logic                         r_s2_in_spr;
  logic                         r_s2_blank;
  tile_e                        r_s2_type;
  rgb_t                         r_s2_spr;

  rgb_t                         r_shadow [N_VIEWS];
  rgb_t                         w_pub    [N_VIEWS];
  rgb_t                         w_comp;

  logic                         w_issue;
  logic [COORD_W-1:0]           w_cam_x;
  logic [COORD_W-1:0]           w_cam_y;
  logic [1:0]                   w_dir;
  logic [TILE_LOG2-1:0]         w_wx_lo;
  logic [TILE_LOG2-1:0]         w_wy_lo;
  logic                         w_in_map;
  logic                         w_in_spr;
  logic                         w_blank;
  logic [c_map_aw-1:0]          w_map_addr;
  logic [c_spr_aw-1:0]          w_spr_addr;

  assign w_issue = (r_state == ST_ISSUE);
  assign w_cam_x = r_cam_x[int'(r_slot)*COORD_W +: COORD_W];
  assign w_cam_y = r_cam_y[int'(r_slot)*COORD_W +: COORD_W];
  assign w_dir   = r_dir[int'(r_slot)*2 +: 2];

  viewport_addr_gen #(
    .TILE_LOG2 (TILE_LOG2),
    .MAP_W     (MAP_W),
    .MAP_H     (MAP_H),
    .VIEW_W    (VIEW_W),
    .VIEW_H    (VIEW_H),
    .SPR_SIZE  (SPR_SIZE),
    .COORD_W   (COORD_W),
    .MAP_AW    (c_map_aw),
    .SPR_AW    (c_spr_aw)
  ) u_addr_gen (
    .cam_x    (w_cam_x),
    .cam_y    (w_cam_y),
    .dir      (w_dir),
    .draw_x   (r_draw_x),
    .draw_y   (r_draw_y),
    .wx_lo    (w_wx_lo),
    .wy_lo    (w_wy_lo),
    .in_map   (w_in_map),
    .in_spr   (w_in_spr),
    .blank    (w_blank),
    .map_addr (w_map_addr),
    .spr_addr (w_spr_addr)
  );

  assign map_addr  = w_issue ? w_map_addr : '0;
  assign spr_addr  = w_issue ? w_spr_addr : '0;
  assign tile_addr = r_s1_valid ? {map_data, r_s1_wy_lo, r_s1_wx_lo} : '0;

  always_comb begin
    w_comp = '0;
    if (r_s2_blank)
      w_comp = '0;
    else if (r_s2_in_spr && (r_s2_spr != KEY_RGB))
      w_comp = r_s2_spr;
    else if (r_s2_in_map && (r_s2_type != TILE_VOID))
      w_comp = tile_data;
  end

  // The last view composites in the same cycle as publish, so bypass its shadow.
  for (genvar v = 0; v < N_VIEWS; v++) begin : g_pub
    assign w_pub[v] = (r_s2_valid && (r_s2_view == c_slot_w'(v))) ? w_comp : r_shadow[v];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_drain     <= 1'b0;
      r_draw_x    <= '0;
      r_draw_y    <= '0;
      r_cam_x     <= '0;
      r_cam_y     <= '0;
      r_dir       <= '0;
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rgb_valid <= 1'b0;
      if (pix_ce && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (pix_ce) begin
            r_draw_x <= DrawX;
            r_draw_y <= DrawY;
            r_cam_x  <= cam_x;
            r_cam_y  <= cam_y;
            r_dir    <= dir;
            r_slot   <= '0;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_slot == c_last_slot) begin
            r_drain <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_slot <= r_slot + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state     <= ST_IDLE;
            r_rgb_valid <= 1'b1;
            for (int v = 0; v < N_VIEWS; v++)
              r_rgb[v*24 +: 24] <= w_pub[v];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_view   <= '0;
      r_s1_in_map <= 1'b0;
      r_s1_in_spr <= 1'b0;
      r_s1_blank  <= 1'b0;
      r_s1_wx_lo  <= '0;
      r_s1_wy_lo  <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_view   <= '0;
      r_s2_in_map <= 1'b0;
      r_s2_in_spr <= 1'b0;
      r_s2_blank  <= 1'b0;
      r_s2_type   <= TILE_VOID;
      r_s2_spr    <= '0;
      for (int v = 0; v < N_VIEWS; v++)
        r_shadow[v] <= '0;
    end else begin
      r_s1_valid  <= w_issue;
      r_s1_view   <= r_slot;
      r_s1_in_map <= w_in_map;
      r_s1_in_spr <= w_in_spr;
      r_s1_blank  <= w_blank;
      r_s1_wx_lo  <= w_wx_lo;
      r_s1_wy_lo  <= w_wy_lo;
      r_s2_valid  <= r_s1_valid;
      r_s2_view   <= r_s1_view;
      r_s2_in_map <= r_s1_in_map;
      r_s2_in_spr <= r_s1_in_spr;
      r_s2_blank  <= r_s1_blank;
      r_s2_type   <= tile_e'(map_data);
      r_s2_spr    <= spr_data;
      if (r_s2_valid)
        r_shadow[r_s2_view] <= w_comp;
    end
  end

  assign rgb       = r_rgb;
  assign rgb_valid = r_rgb_valid;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire
